osd_num_overlay: RTL and testbench
==================================

# osd_num_overlay

Parametrised on-screen numeric overlay for the VGA output path. It composites up to NUM_CH independently placed multi-digit BCD readouts (heart rate, temperature, blood oxygen and similar) over the camera pixel stream. Glyphs come from one shared glyph ROM. It sits between the VGA timing/camera pixel mux and the VGA pins, in the lcd clock domain, and replaces per-field hard-coded digit windows with a single pipelined engine. It adds frame-synchronous value latching, leading-zero blanking, per-channel colour, and an opaque/transparent mode.

## Interface
- NUM_CH, 4: number of numeric fields.
- DIGITS, 4: digits per field.
- GLYPH_W, 16: glyph width in pixels; power of two, at most 32.
- GLYPH_H, 32: glyph height in rows.
- ROM_LAT, 1: glyph ROM read latency in cycles, 1..3.
- BG_COLOR, 24'h000000: box fill for opaque channels.

- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- cnt_h, cnt_v  in  12 each  active-area pixel coordinates, valid when de_in=1.
- de_in  in  1  active video.
- hs_in, vs_in  in  1 each  syncs, active-low.
- rgb_in  in  24  background pixel {R,G,B}.
- ch_x, ch_y  in  NUM_CH*12 each  top-left corner of each field; channel i uses bits [i*12+:12].
- ch_bcd  in  NUM_CH*DIGITS*4  BCD digits; digit 0 is the leftmost.
- ch_fg  in  NUM_CH*24  foreground colour per channel.
- ch_en, ch_lz, ch_opq  in  NUM_CH each  per channel: enable, leading-zero blanking, opaque box.
- glyph_addr  out  $clog2(11*GLYPH_H)  glyph ROM address: code*GLYPH_H + row.
- glyph_data  in  GLYPH_W  ROM row; MSB is the leftmost pixel.
- rgb_out  out  24  composited pixel.
- de_out, hs_out, vs_out  out  1 each  delayed controls.

## Operation
- **Shadow latch.** vs_in is sampled each cycle. On the first cycle vs_in=0 after a sample of 1, all ch_* inputs are copied into shadow registers. Compositing uses only the shadow copy, so values never change mid-frame.
- **Stage 0, hit test.** Channel i hits when all of the following hold:
  - de_in=1 and shadow ch_en[i]=1;
  - x_i ≤ cnt_h < x_i + DIGITS*GLYPH_W (unsigned, 13-bit sums, no wrap);
  - y_i ≤ cnt_v < y_i + GLYPH_H.
- **Priority.** If several channels hit, the lowest index wins.
- **Per-pixel fields.** For the winning channel: digit = (cnt_h − x_i) >> log2(GLYPH_W); col = low bits of that difference; row = cnt_v − y_i.
- **Glyph codes.**
  - Codes 0–9 are digits.
  - Code 10 is blank; its ROM rows are all zero.
  - A BCD value above 9 renders as code 10.
  - When ch_lz=1, every digit left of the first nonzero digit renders as code 10. The last digit is never blanked.
- **Stages 1..ROM_LAT.** glyph_addr is registered at the end of stage 0. col, channel index, hit flag, rgb_in and controls travel through a matching delay line.
- **Final stage.** Let pix = glyph_data[GLYPH_W−1−col].
  - hit and pix=1: output ch_fg.
  - hit, pix=0, opaque: output BG_COLOR.
  - hit, pix=0, transparent: output rgb_in.
  - no hit: output rgb_in.
  - de=0: output 24'h0.

## Timing
- Fixed latency L = ROM_LAT + 2 cycles from inputs to rgb_out, de_out, hs_out and vs_out, for every pixel. Controls are delayed by exactly L.
- No stalls and no back-pressure. One pixel is processed per clock.
- **Reset values.** rgb_out=0, de_out=0, hs_out=1, vs_out=1, glyph_addr=0. All delay-line contents are cleared to the same values. Shadow ch_en=0, so nothing is overlaid until the first vs falling edge after reset.
- Reset asserted mid-frame clears the pipeline on the next edge. Output stays blank until the next vs edge.
- A field that extends past the active area is clipped naturally. There is no wrap back to column 0.
- ch_* changing on the same cycle as the vs falling edge: the new value is latched.

## Test plan
- **Single field.** NUM_CH=1, x=100, y=50, bcd=1234, fg=FF0000, transparent, ROM_LAT=1, with a ROM model. Required: red glyph pixels appear at cnt_h 100..163 and rows 50..81, exactly 3 cycles after the matching input. Every other pixel equals rgb_in delayed by 3.
- **Leading-zero blanking.** bcd=0042 with ch_lz=1: digits 0–1 show no fg pixels. bcd=0000 with ch_lz=1: only digit 3 shows "0". bcd=A5 nibble: that digit renders blank.
- **Overlap priority.** Channel 0 and channel 1 both at (200,200), fg 00FF00 and 0000FF respectively. Required: every overlapping lit pixel is 00FF00.
- **Opaque mode.** ch_opq=1, BG_COLOR=101010: unlit pixels inside the box equal 101010; pixels outside the box equal rgb_in.
- **Frame latch.** Change bcd from 11 to 22 mid-frame at line 300. Required: the rest of that frame still shows 11; the next frame shows 22. A change on the same cycle as the vs falling edge shows up in the next frame.
- **Reset and edges.** Assert rst for one cycle mid-line: outputs match the reset values on the next cycle. x=630 with DIGITS=4: no stray pixels at cnt_h 0..29. hs_out/vs_out equal hs_in/vs_in delayed by L, for ROM_LAT=1 and ROM_LAT=3.

Source files
------------

// File: rtl/osd_num_overlay.sv
// Numeric on-screen overlay: composites NUM_CH multi-digit BCD fields from a shared
// glyph ROM over the pixel stream with a fixed ROM_LAT+2 cycle latency.
module osd_num_overlay #(
  parameter int          NUM_CH   = 4,
  parameter int          DIGITS   = 4,
  parameter int          GLYPH_W  = 16,
  parameter int          GLYPH_H  = 32,
  parameter int          ROM_LAT  = 1,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  localparam int         AW       = $clog2(11*GLYPH_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [11:0]              cnt_h,
  input  logic [11:0]              cnt_v,
  input  logic                     de_in,
  input  logic                     hs_in,
  input  logic                     vs_in,
  input  logic [23:0]              rgb_in,
  input  logic [NUM_CH*12-1:0]     ch_x,
  input  logic [NUM_CH*12-1:0]     ch_y,
  input  logic [NUM_CH*DIGITS*4-1:0] ch_bcd,
  input  logic [NUM_CH*24-1:0]     ch_fg,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        ch_lz,
  input  logic [NUM_CH-1:0]        ch_opq,
  output logic [AW-1:0]            glyph_addr,
  input  logic [GLYPH_W-1:0]       glyph_data,
  output logic [23:0]              rgb_out,
  output logic                     de_out,
  output logic                     hs_out,
  output logic                     vs_out
);

  localparam int CW = $clog2(GLYPH_W);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int XW = CW + DW;
  localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int NW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = DIGITS * 4;
  localparam int D  = ROM_LAT + 1;

  logic                       vs_prev_q;
  logic [NUM_CH*12-1:0]       sh_x_q, sh_y_q;
  logic [NUM_CH*BW-1:0]       sh_bcd_q;
  logic [NUM_CH*24-1:0]       sh_fg_q;
  logic [NUM_CH-1:0]          sh_en_q, sh_lz_q, sh_opq_q;

  // Shadow copy taken on the first low sample of vs so fields never tear mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b0;
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_bcd_q  <= '0;
      sh_fg_q   <= '0;
      sh_en_q   <= '0;
      sh_lz_q   <= '0;
      sh_opq_q  <= '0;
    end else begin
      vs_prev_q <= vs_in;
      if (vs_prev_q && !vs_in) begin
        sh_x_q   <= ch_x;
        sh_y_q   <= ch_y;
        sh_bcd_q <= ch_bcd;
        sh_fg_q  <= ch_fg;
        sh_en_q  <= ch_en;
        sh_lz_q  <= ch_lz;
        sh_opq_q <= ch_opq;
      end
    end
  end

  logic [NUM_CH-1:0] hit_v;
  logic [12:0]       h13, v13;
  assign h13 = {1'b0, cnt_h};
  assign v13 = {1'b0, cnt_v};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hit
    logic [12:0] x0, y0;
    assign x0 = {1'b0, sh_x_q[i*12 +: 12]};
    assign y0 = {1'b0, sh_y_q[i*12 +: 12]};
    assign hit_v[i] = de_in && sh_en_q[i] &&
                      (h13 >= x0) && (h13 < x0 + 13'(DIGITS*GLYPH_W)) &&
                      (v13 >= y0) && (v13 < y0 + 13'(GLYPH_H));
  end

  logic          hit_any;
  logic [NW-1:0] win;

  always_comb begin
    hit_any = |hit_v;
    win     = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (hit_v[i]) win = NW'(i);
    end
  end

  logic [11:0]   win_x, win_y;
  logic [BW-1:0] win_bcd;
  logic          win_lz;
  logic [XW-1:0] dx;
  logic [CW-1:0] col;
  logic [DW-1:0] dig;
  logic [RW-1:0] row;

  assign win_x   = sh_x_q[win*12 +: 12];
  assign win_y   = sh_y_q[win*12 +: 12];
  assign win_bcd = sh_bcd_q[win*BW +: BW];
  assign win_lz  = sh_lz_q[win];
  assign dx      = XW'(cnt_h - win_x);
  assign col     = dx[CW-1:0];
  assign dig     = dx[XW-1:CW];
  assign row     = RW'(cnt_v - win_y);

  logic [3:0]    nib, code;
  logic          all_zero;
  logic [AW-1:0] addr_d;

  // Code 10 is the blank glyph: used for invalid nibbles and blanked leading zeros.
  always_comb begin
    nib      = win_bcd[dig*4 +: 4];
    all_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j <= int'(dig) && win_bcd[j*4 +: 4] != 4'd0) all_zero = 1'b0;
    end
    code = nib;
    if (nib > 4'd9 || (win_lz && all_zero && int'(dig) != DIGITS-1)) code = 4'd10;
    addr_d = hit_any ? (AW'(code) * AW'(GLYPH_H) + AW'(row)) : '0;
  end

  logic [AW-1:0]          glyph_addr_q;
  logic [D-1:0]           hit_q, de_q, hs_q, vs_q;
  logic [D-1:0][CW-1:0]   col_q;
  logic [D-1:0][NW-1:0]   ch_q;
  logic [D-1:0][23:0]     rgb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      glyph_addr_q <= '0;
      hit_q        <= '0;
      de_q         <= '0;
      hs_q         <= '1;
      vs_q         <= '1;
      col_q        <= '0;
      ch_q         <= '0;
      rgb_q        <= '0;
    end else begin
      glyph_addr_q <= addr_d;
      hit_q[0]     <= hit_any;
      de_q[0]      <= de_in;
      hs_q[0]      <= hs_in;
      vs_q[0]      <= vs_in;
      col_q[0]     <= col;
      ch_q[0]      <= win;
      rgb_q[0]     <= rgb_in;
      for (int k = 1; k < D; k++) begin
        hit_q[k] <= hit_q[k-1];
        de_q[k]  <= de_q[k-1];
        hs_q[k]  <= hs_q[k-1];
        vs_q[k]  <= vs_q[k-1];
        col_q[k] <= col_q[k-1];
        ch_q[k]  <= ch_q[k-1];
        rgb_q[k] <= rgb_q[k-1];
      end
    end
  end

  assign glyph_addr = glyph_addr_q;

  logic        pix;
  logic [23:0] rgb_d;
  logic [23:0] rgb_out_q;
  logic        de_out_q, hs_out_q, vs_out_q;

  // GLYPH_W is a power of two, so GLYPH_W-1-col is simply ~col.
  always_comb begin
    pix   = glyph_data[~col_q[D-1]];
    rgb_d = 24'h0;
    if (de_q[D-1]) begin
      if (hit_q[D-1] && pix)                 rgb_d = sh_fg_q[ch_q[D-1]*24 +: 24];
      else if (hit_q[D-1] && sh_opq_q[ch_q[D-1]]) rgb_d = BG_COLOR;
      else                                   rgb_d = rgb_q[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_out_q <= 24'h0;
      de_out_q  <= 1'b0;
      hs_out_q  <= 1'b1;
      vs_out_q  <= 1'b1;
    end else begin
      rgb_out_q <= rgb_d;
      de_out_q  <= de_q[D-1];
      hs_out_q  <= hs_q[D-1];
      vs_out_q  <= vs_q[D-1];
    end
  end

  assign rgb_out = rgb_out_q;
  assign de_out  = de_out_q;
  assign hs_out  = hs_out_q;
  assign vs_out  = vs_out_q;

endmodule

// File: tb/tb_osd_num_overlay.sv
// Directed bench: two overlay instances (ROM_LAT 1 and 3) share stimulus; each
// pixel is checked against a hand-derived colour at its own fixed latency.
module tb_osd_num_overlay;

  localparam logic [23:0] BGI = 24'hABCDEF;
  localparam logic [23:0] IDL = 24'h5A5A5A;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] BLU = 24'h0000FF;
  localparam logic [23:0] BOX = 24'h101010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] cnt_h = '0, cnt_v = '0;
  logic        de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [23:0] rgb_in = IDL;
  logic [23:0] ch_x = '0, ch_y = '0;
  logic [31:0] ch_bcd = '0;
  logic [47:0] ch_fg = '0;
  logic [1:0]  ch_en = '0, ch_lz = '0, ch_opq = '0;

  logic [8:0]  addr_a, addr_b;
  logic [15:0] data_a = '0, rb1 = '0, rb2 = '0, data_b = '0;
  logic [23:0] rgb_a, rgb_b;
  logic        de_a, hs_a, vs_a, de_b, hs_b, vs_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  osd_num_overlay #(.NUM_CH(2), .DIGITS(4), .GLYPH_W(16), .GLYPH_H(32),
                    .ROM_LAT(1), .BG_COLOR(BOX)) u_a (
    .clk(clk), .rst(rst), .cnt_h(cnt_h), .cnt_v(cnt_v), .de_in(de_in),
    .hs_in(hs_in), .vs_in(vs_in), .rgb_in(rgb_in), .ch_x(ch_x), .ch_y(ch_y),
    .ch_bcd(ch_bcd), .ch_fg(ch_fg), .ch_en(ch_en), .ch_lz(ch_lz), .ch_opq(ch_opq),
    .glyph_addr(addr_a), .glyph_data(data_a), .rgb_out(rgb_a),
    .de_out(de_a), .hs_out(hs_a), .vs_out(vs_a));

  osd_num_overlay #(.NUM_CH(2), .DIGITS(4), .GLYPH_W(16), .GLYPH_H(32),
                    .ROM_LAT(3), .BG_COLOR(BOX)) u_b (
    .clk(clk), .rst(rst), .cnt_h(cnt_h), .cnt_v(cnt_v), .de_in(de_in),
    .hs_in(hs_in), .vs_in(vs_in), .rgb_in(rgb_in), .ch_x(ch_x), .ch_y(ch_y),
    .ch_bcd(ch_bcd), .ch_fg(ch_fg), .ch_en(ch_en), .ch_lz(ch_lz), .ch_opq(ch_opq),
    .glyph_addr(addr_b), .glyph_data(data_b), .rgb_out(rgb_b),
    .de_out(de_b), .hs_out(hs_b), .vs_out(vs_b));

  // Glyph for digit c: columns 0, 15 and 1+c lit on even rows; odd rows and code >= 10 blank.
  function automatic logic [15:0] glyph(input logic [8:0] a);
    logic [3:0] c;
    c = a[8:5];
    if (c > 4'd9 || a[0]) return 16'h0000;
    return 16'h8001 | (16'h4000 >> c);
  endfunction

  always @(posedge clk) begin
    data_a <= glyph(addr_a);
    rb1    <= glyph(addr_b);
    rb2    <= rb1;
    data_b <= rb2;
  end

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setch(input int i, input logic [11:0] x, input logic [11:0] y,
                       input logic [15:0] bcd, input logic [23:0] fg,
                       input logic en, input logic lz, input logic opq);
    ch_x[i*12 +: 12]  = x;
    ch_y[i*12 +: 12]  = y;
    ch_bcd[i*16 +: 16] = bcd;
    ch_fg[i*24 +: 24] = fg;
    ch_en[i]  = en;
    ch_lz[i]  = lz;
    ch_opq[i] = opq;
  endtask

  task automatic idle();
    cnt_h = '0; cnt_v = '0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1; rgb_in = IDL;
  endtask

  // One pixel in, then idle; check instance A 3 cycles later and B 5 cycles later.
  task automatic px(input logic [11:0] h, input logic [11:0] v, input logic d,
                    input logic hs, input logic vs, input logic [23:0] exp, input string tag);
    cnt_h = h; cnt_v = v; de_in = d; hs_in = hs; vs_in = vs; rgb_in = BGI;
    @(posedge clk); #1;
    idle();
    repeat (2) @(posedge clk); #1;
    chk({tag, "/a_rgb"}, rgb_a, exp);
    chk({tag, "/a_ctl"}, {21'd0, de_a, hs_a, vs_a}, {21'd0, d, hs, vs});
    repeat (2) @(posedge clk); #1;
    chk({tag, "/b_rgb"}, rgb_b, exp);
    chk({tag, "/b_ctl"}, {21'd0, de_b, hs_b, vs_b}, {21'd0, d, hs, vs});
  endtask

  task automatic vsync();
    px(12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 24'h0, "vsync");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/a_rgb"}, rgb_a, 24'h0);
    chk({tag, "/a_ctl"}, {21'd0, de_a, hs_a, vs_a}, 24'd3);
    chk({tag, "/b_rgb"}, rgb_b, 24'h0);
    chk({tag, "/b_ctl"}, {21'd0, de_b, hs_b, vs_b}, 24'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    setch(0, 12'd100, 12'd50, 16'h4321, RED, 1'b1, 1'b0, 1'b0);
    setch(1, 12'd0, 12'd0, 16'h0000, BLU, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk_reset("reset");
    chk("reset/a_addr", {15'd0, addr_a}, 24'd0);
    chk("reset/b_addr", {15'd0, addr_b}, 24'd0);
    rst = 1'b0;

    px(12'd100, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "no_latch_yet");
    vsync();

    // bcd 1,2,3,4 at (100,50), red, transparent
    px(12'd100, 12'd50, 1'b1, 1'b1, 1'b1, RED, "d0c0r0");
    px(12'd100, 12'd51, 1'b1, 1'b1, 1'b1, BGI, "odd_row");
    px(12'd101, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "d0c1");
    px(12'd102, 12'd50, 1'b1, 1'b1, 1'b1, RED, "d0c2");
    px(12'd99,  12'd50, 1'b1, 1'b1, 1'b1, BGI, "left_out");
    px(12'd163, 12'd50, 1'b1, 1'b1, 1'b1, RED, "right_edge");
    px(12'd164, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "right_out");
    px(12'd119, 12'd52, 1'b1, 1'b1, 1'b1, RED, "d1c3");
    px(12'd100, 12'd80, 1'b1, 1'b1, 1'b1, RED, "row30");
    px(12'd100, 12'd81, 1'b1, 1'b1, 1'b1, BGI, "row31");
    px(12'd100, 12'd82, 1'b1, 1'b1, 1'b1, BGI, "below");
    px(12'd100, 12'd49, 1'b1, 1'b1, 1'b1, BGI, "above");
    px(12'd153, 12'd60, 1'b1, 1'b1, 1'b1, RED, "d3c5");
    px(12'd150, 12'd60, 1'b1, 1'b1, 1'b1, BGI, "d3c2");
    px(12'd100, 12'd50, 1'b0, 1'b1, 1'b1, 24'h0, "de_off");
    px(12'd100, 12'd50, 1'b1, 1'b0, 1'b1, RED, "hs_low");

    // 0,0,4,2 with leading-zero blanking
    setch(0, 12'd100, 12'd50, 16'h2400, RED, 1'b1, 1'b1, 1'b0);
    vsync();
    px(12'd100, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "lz_d0");
    px(12'd116, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "lz_d1");
    px(12'd132, 12'd50, 1'b1, 1'b1, 1'b1, RED, "lz_d2c0");
    px(12'd137, 12'd50, 1'b1, 1'b1, 1'b1, RED, "lz_d2c5");
    px(12'd151, 12'd50, 1'b1, 1'b1, 1'b1, RED, "lz_d3c3");

    setch(0, 12'd100, 12'd50, 16'h0000, RED, 1'b1, 1'b1, 1'b0);
    vsync();
    px(12'd100, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "z_d0");
    px(12'd132, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "z_d2");
    px(12'd148, 12'd50, 1'b1, 1'b1, 1'b1, RED, "z_d3c0");
    px(12'd149, 12'd50, 1'b1, 1'b1, 1'b1, RED, "z_d3c1");

    // 0,A,3,4 without blanking: zero shown, A blank
    setch(0, 12'd100, 12'd50, 16'h43A0, RED, 1'b1, 1'b0, 1'b0);
    vsync();
    px(12'd100, 12'd50, 1'b1, 1'b1, 1'b1, RED, "nolz_d0");
    px(12'd116, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "bad_nib_c0");
    px(12'd117, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "bad_nib_c1");
    px(12'd132, 12'd50, 1'b1, 1'b1, 1'b1, RED, "after_nib");

    // overlap: ch0 1111 green transparent, ch1 8888 blue opaque
    setch(0, 12'd200, 12'd200, 16'h1111, GRN, 1'b1, 1'b0, 1'b0);
    setch(1, 12'd200, 12'd200, 16'h8888, BLU, 1'b1, 1'b0, 1'b1);
    vsync();
    px(12'd200, 12'd200, 1'b1, 1'b1, 1'b1, GRN, "ovl_both");
    px(12'd202, 12'd200, 1'b1, 1'b1, 1'b1, GRN, "ovl_ch0");
    px(12'd209, 12'd200, 1'b1, 1'b1, 1'b1, BGI, "ovl_ch1_only");
    px(12'd200, 12'd201, 1'b1, 1'b1, 1'b1, BGI, "ovl_unlit");

    setch(1, 12'd300, 12'd300, 16'h8888, BLU, 1'b1, 1'b0, 1'b1);
    vsync();
    px(12'd309, 12'd300, 1'b1, 1'b1, 1'b1, BLU, "opq_lit");
    px(12'd301, 12'd300, 1'b1, 1'b1, 1'b1, BOX, "opq_unlit");
    px(12'd301, 12'd301, 1'b1, 1'b1, 1'b1, BOX, "opq_odd");
    px(12'd300, 12'd331, 1'b1, 1'b1, 1'b1, BOX, "opq_bottom");
    px(12'd299, 12'd300, 1'b1, 1'b1, 1'b1, BGI, "opq_left_out");
    px(12'd300, 12'd332, 1'b1, 1'b1, 1'b1, BGI, "opq_below");
    px(12'd363, 12'd300, 1'b1, 1'b1, 1'b1, BLU, "opq_right");
    px(12'd364, 12'd300, 1'b1, 1'b1, 1'b1, BGI, "opq_right_out");

    // frame latch: 0,0,1,1 then 0,0,2,2 mid-frame
    setch(1, 12'd300, 12'd300, 16'h8888, BLU, 1'b0, 1'b0, 1'b1);
    setch(0, 12'd100, 12'd50, 16'h1100, RED, 1'b1, 1'b0, 1'b0);
    vsync();
    px(12'd134, 12'd50, 1'b1, 1'b1, 1'b1, RED, "f11_c2");
    px(12'd135, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "f11_c3");
    ch_bcd[15:0] = 16'h2200;
    px(12'd134, 12'd60, 1'b1, 1'b1, 1'b1, RED, "mid_c2");
    px(12'd135, 12'd60, 1'b1, 1'b1, 1'b1, BGI, "mid_c3");
    vsync();
    px(12'd135, 12'd50, 1'b1, 1'b1, 1'b1, RED, "f22_c3");
    px(12'd134, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "f22_c2");
    ch_bcd[15:0] = 16'h3300;
    vsync();
    px(12'd136, 12'd50, 1'b1, 1'b1, 1'b1, RED, "f33_c4");
    px(12'd135, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "f33_c3");

    // clipping near the right edge and at the top of the coordinate range
    setch(0, 12'd630, 12'd50, 16'h0000, RED, 1'b1, 1'b0, 1'b0);
    vsync();
    px(12'd630, 12'd50, 1'b1, 1'b1, 1'b1, RED, "x630_c0");
    px(12'd631, 12'd50, 1'b1, 1'b1, 1'b1, RED, "x630_c1");
    px(12'd0,   12'd50, 1'b1, 1'b1, 1'b1, BGI, "x630_h0");
    px(12'd29,  12'd50, 1'b1, 1'b1, 1'b1, BGI, "x630_h29");
    setch(0, 12'd4080, 12'd50, 16'h0000, RED, 1'b1, 1'b0, 1'b0);
    vsync();
    px(12'd4081, 12'd50, 1'b1, 1'b1, 1'b1, RED, "x4080_c1");
    px(12'd4095, 12'd50, 1'b1, 1'b1, 1'b1, RED, "x4080_c15");
    px(12'd0,    12'd50, 1'b1, 1'b1, 1'b1, BGI, "x4080_h0");
    px(12'd16,   12'd50, 1'b1, 1'b1, 1'b1, BGI, "x4080_h16");

    // reset for one cycle with a lit pixel in flight
    setch(0, 12'd100, 12'd50, 16'h0000, RED, 1'b1, 1'b0, 1'b0);
    vsync();
    cnt_h = 12'd100; cnt_v = 12'd50; de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b1; rgb_in = BGI;
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("rst_now");
    chk("rst_now/a_addr", {15'd0, addr_a}, 24'd0);
    chk("rst_now/b_addr", {15'd0, addr_b}, 24'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_reset("rst_flush");
    end
    px(12'd100, 12'd50, 1'b1, 1'b1, 1'b1, BGI, "post_rst_off");
    vsync();
    px(12'd100, 12'd50, 1'b1, 1'b1, 1'b1, RED, "post_rst_on");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
